// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MIPS control-flow opcodes/functs, redirect FSM
// state encoding, link-register default and the ID control-flow decoder.
package pipeline_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] LINK_REG_DEFAULT = 5'd31;

  // Encoding base for the redirect FSM; IDLE must be the reset encoding.
  localparam logic RESET_STATE_IDLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = {1'b0, RESET_STATE_IDLE},
    ST_STALL    = {1'b0, ~RESET_STATE_IDLE},
    ST_REDIRECT = {1'b1, RESET_STATE_IDLE}
  } redirect_state_t;

  typedef struct packed {
    logic is_jump;     // j, jal, jr, jalr
    logic is_branch;   // beq, bne, blez, bgtz
    logic is_direct;   // j, jal: target from the instruction index
    logic needs_opnd;  // resolution depends on rs/rt
    logic is_link;     // jal, jalr
    logic link_rd;     // jalr: link destination taken from rd
  } ctrl_dec_t;

  function automatic ctrl_dec_t decode_ctrl(input logic [31:0] instr);
    ctrl_dec_t  d;
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    d  = '0;
    unique case (op)
      OP_J:    begin d.is_jump = 1'b1; d.is_direct = 1'b1; end
      OP_JAL:  begin d.is_jump = 1'b1; d.is_direct = 1'b1; d.is_link = 1'b1; end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        d.is_branch  = 1'b1;
        d.needs_opnd = 1'b1;
      end
      OP_SPECIAL: begin
        if (fn == FN_JR) begin
          d.is_jump    = 1'b1;
          d.needs_opnd = 1'b1;
        end else if (fn == FN_JALR) begin
          d.is_jump    = 1'b1;
          d.needs_opnd = 1'b1;
          d.is_link    = 1'b1;
          d.link_rd    = 1'b1;
        end
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/branch_redirect_unit_if.sv
// ID-stage control-flow bus: ID instruction/operands in, redirect, flush,
// stall, link-write and statistics out. The unit uses the slave modport.
interface branch_redirect_unit_if;

  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        opnd_ready;

  logic        ctrl_jump;
  logic [31:0] jump_to_where;
  logic        ctrl_branch;
  logic [31:0] branch_to_where;
  logic        flush_ifid;
  logic        id_kill;
  logic        stall_req;
  logic        link_we;
  logic [4:0]  link_addr;
  logic [31:0] link_data;
  logic [31:0] taken_cnt;
  logic [31:0] not_taken_cnt;

  modport master (
    output id_valid, id_instr, id_pc_plus4, rs_val, rt_val, opnd_ready,
    input  ctrl_jump, jump_to_where, ctrl_branch, branch_to_where,
           flush_ifid, id_kill, stall_req, link_we, link_addr, link_data,
           taken_cnt, not_taken_cnt
  );

  modport slave (
    input  id_valid, id_instr, id_pc_plus4, rs_val, rt_val, opnd_ready,
    output ctrl_jump, jump_to_where, ctrl_branch, branch_to_where,
           flush_ifid, id_kill, stall_req, link_we, link_addr, link_data,
           taken_cnt, not_taken_cnt
  );

endinterface

// File: rtl/branch_cond_cmp.sv
// Branch condition evaluator for beq/bne/blez/bgtz on forwarded operands;
// any other opcode yields not-taken.
module branch_cond_cmp
  import pipeline_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken
);

  logic rs_eq_rt;
  logic rs_neg;
  logic rs_zero;

  assign rs_eq_rt = (rs_val == rt_val);
  assign rs_neg   = rs_val[31];
  assign rs_zero  = (rs_val == 32'd0);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    taken = 1'b0;
    unique case (opcode)
      OP_BEQ:  taken = rs_eq_rt;
      OP_BNE:  taken = ~rs_eq_rt;
      OP_BLEZ: taken = rs_neg | rs_zero;
      OP_BGTZ: taken = ~rs_neg & ~rs_zero;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// ID-stage control-flow resolution: registered one-cycle redirect/flush/link
// pulses, operand-wait stall. Optional branch statistics under BRANCH_STATS_EN.
module branch_redirect_unit
  import pipeline_pkg::*;
#(
  parameter int LINK_REG = 31
) (
  input logic                  clk,
  input logic                  rst,
  branch_redirect_unit_if.slave bus
);

  redirect_state_t state;
  ctrl_dec_t       dec;

  logic        br_taken;
  logic        active;
  logic        wait_opnd;
  logic        resolve;
  logic        redirect;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [4:0]  link_dst;

  assign dec = decode_ctrl(bus.id_instr);

  branch_cond_cmp u_cond_cmp (
    .opcode (bus.id_instr[31:26]),
    .rs_val (bus.rs_val),
    .rt_val (bus.rt_val),
    .taken  (br_taken)
  );

  // The instruction sitting in ID during REDIRECT is the wrong-path one being
  // killed, so nothing is decoded from it in that state.
  assign active    = (state != ST_REDIRECT) & bus.id_valid & (dec.is_jump | dec.is_branch);
  assign wait_opnd = active & dec.needs_opnd & ~bus.opnd_ready;
  assign resolve   = active & ~wait_opnd;
  assign redirect  = resolve & (dec.is_jump | (dec.is_branch & br_taken));

  assign bus.stall_req = wait_opnd;

  assign br_target  = bus.id_pc_plus4
                    + {{14{bus.id_instr[15]}}, bus.id_instr[15:0], 2'b00};
  assign jmp_target = dec.is_direct ? {bus.id_pc_plus4[31:28], bus.id_instr[25:0], 2'b00}
                                    : bus.rs_val;
  assign link_dst   = dec.link_rd ? bus.id_instr[15:11] : 5'(LINK_REG);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= ST_IDLE;
      bus.ctrl_jump       <= 1'b0;
      bus.ctrl_branch     <= 1'b0;
      bus.jump_to_where   <= '0;
      bus.branch_to_where <= '0;
      bus.flush_ifid      <= 1'b0;
      bus.id_kill         <= 1'b0;
      bus.link_we         <= 1'b0;
      bus.link_addr       <= '0;
      bus.link_data       <= '0;
    end else begin
      bus.ctrl_jump   <= 1'b0;
      bus.ctrl_branch <= 1'b0;
      bus.flush_ifid  <= 1'b0;
      bus.id_kill     <= 1'b0;
      bus.link_we     <= 1'b0;
      unique case (state)
        ST_IDLE, ST_STALL: begin
          if (redirect) begin
            state          <= ST_REDIRECT;
            bus.flush_ifid <= 1'b1;
            bus.id_kill    <= 1'b1;
            if (dec.is_jump) begin
              bus.ctrl_jump     <= 1'b1;
              bus.jump_to_where <= jmp_target;
            end else begin
              bus.ctrl_branch     <= 1'b1;
              bus.branch_to_where <= br_target;
            end
            if (dec.is_link) begin
              bus.link_we   <= 1'b1;
              bus.link_addr <= link_dst;
              bus.link_data <= bus.id_pc_plus4;
            end
          end else if (wait_opnd) begin
            state <= ST_STALL;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REDIRECT: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating counters of resolved conditional branches; jumps not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.taken_cnt     <= '0;
      bus.not_taken_cnt <= '0;
    end else if (resolve && dec.is_branch) begin
      if (br_taken) begin
        if (bus.taken_cnt != 32'hFFFF_FFFF) bus.taken_cnt <= bus.taken_cnt + 32'd1;
      end else begin
        if (bus.not_taken_cnt != 32'hFFFF_FFFF) bus.not_taken_cnt <= bus.not_taken_cnt + 32'd1;
      end
    end
  end
`else
  assign bus.taken_cnt     = '0;
  assign bus.not_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed self-checking bench for branch_redirect_unit: redirect pulses,
// targets, stall, link writes, killed back-to-back control, mid-pulse reset.
`timescale 1ns/1ps
module tb_branch_redirect_unit;
  import pipeline_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   exp_taken;
  int   exp_nt;

  branch_redirect_unit_if bus ();

  branch_redirect_unit #(.LINK_REG(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rd,
                                         input logic [5:0] fn);
    return {6'b000000, rs, 5'd0, rd, 5'd0, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and registered outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc4,
                       input logic [31:0] rs, input logic [31:0] rt, input logic rdy);
    bus.id_valid    = v;
    bus.id_instr    = instr;
    bus.id_pc_plus4 = pc4;
    bus.rs_val      = rs;
    bus.rt_val      = rt;
    bus.opnd_ready  = rdy;
  endtask

  task automatic check_counters(input string tag);
`ifdef BRANCH_STATS_EN
    check({tag, "_taken_cnt"}, bus.taken_cnt, 32'(exp_taken));
    check({tag, "_not_taken_cnt"}, bus.not_taken_cnt, 32'(exp_nt));
`else
    check({tag, "_taken_cnt"}, bus.taken_cnt, 32'd0);
    check({tag, "_not_taken_cnt"}, bus.not_taken_cnt, 32'd0);
`endif
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_taken = 0;
    exp_nt    = 0;
    rst       = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    #12;
    check("rst_ctrl_jump", {31'd0, bus.ctrl_jump}, 32'd0);
    check("rst_ctrl_branch", {31'd0, bus.ctrl_branch}, 32'd0);
    check("rst_jump_to_where", bus.jump_to_where, 32'd0);
    check("rst_branch_to_where", bus.branch_to_where, 32'd0);
    check("rst_flush_kill", {30'd0, bus.flush_ifid, bus.id_kill}, 32'd0);
    check("rst_link", {26'd0, bus.link_we, bus.link_addr}, 32'd0);
    check("rst_link_data", bus.link_data, 32'd0);
    check_counters("rst");
    rst = 1'b0;
    step();

    // beq taken: target 0x3004 + (3 << 2)
    drive(1'b1, i_type(OP_BEQ, 5'd1, 5'd2, 16'h0003), 32'h0000_3004, 32'd5, 32'd5, 1'b1);
    step();
    exp_taken++;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    check("beq_ctrl_branch", {31'd0, bus.ctrl_branch}, 32'd1);
    check("beq_ctrl_jump", {31'd0, bus.ctrl_jump}, 32'd0);
    check("beq_target", bus.branch_to_where, 32'h0000_3010);
    check("beq_flush_kill", {30'd0, bus.flush_ifid, bus.id_kill}, 32'd3);
    check("beq_link_we", {31'd0, bus.link_we}, 32'd0);
    step();
    check("beq_pulse_once", {29'd0, bus.ctrl_branch, bus.flush_ifid, bus.id_kill}, 32'd0);
    check("beq_target_hold", bus.branch_to_where, 32'h0000_3010);
    check_counters("beq");

    // bne not taken
    drive(1'b1, i_type(OP_BNE, 5'd1, 5'd2, 16'h0010), 32'h0000_3104, 32'd7, 32'd7, 1'b1);
    #1;
    check("bne_stall", {31'd0, bus.stall_req}, 32'd0);
    step();
    exp_nt++;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    check("bne_no_pulse", {28'd0, bus.ctrl_branch, bus.ctrl_jump, bus.flush_ifid, bus.id_kill}, 32'd0);
    check("bne_target_hold", bus.branch_to_where, 32'h0000_3010);
    check_counters("bne");

    // jal: {0x3008[31:28], 0xC10, 00}, link to r31 with pc+4
    drive(1'b1, j_type(OP_JAL, 26'h000_0C10), 32'h0000_3008, 32'd0, 32'd0, 1'b0);
    #1;
    check("jal_no_stall", {31'd0, bus.stall_req}, 32'd0);
    step();
    // A taken beq arriving during the redirect cycle is wrong-path
    drive(1'b1, i_type(OP_BEQ, 5'd1, 5'd2, 16'h0040), 32'h0000_300C, 32'd1, 32'd1, 1'b1);
    check("jal_ctrl_jump", {31'd0, bus.ctrl_jump}, 32'd1);
    check("jal_ctrl_branch", {31'd0, bus.ctrl_branch}, 32'd0);
    check("jal_target", bus.jump_to_where, 32'h0000_3040);
    check("jal_link", {26'd0, bus.link_we, bus.link_addr}, {26'd0, 1'b1, 5'd31});
    check("jal_link_data", bus.link_data, 32'h0000_3008);
    check("jal_flush_kill", {30'd0, bus.flush_ifid, bus.id_kill}, 32'd3);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    check("killed_no_pulse", {28'd0, bus.ctrl_branch, bus.ctrl_jump, bus.flush_ifid, bus.link_we}, 32'd0);
    check("killed_target_hold", bus.branch_to_where, 32'h0000_3010);
    check_counters("killed");

    // beq waiting two cycles on operands
    drive(1'b1, i_type(OP_BEQ, 5'd3, 5'd4, 16'h0001), 32'h0000_4000, 32'd9, 32'd9, 1'b0);
    #1;
    check("stall_c1", {31'd0, bus.stall_req}, 32'd1);
    step();
    check("stall_c2", {31'd0, bus.stall_req}, 32'd1);
    check("stall_c2_no_pulse", {29'd0, bus.ctrl_branch, bus.flush_ifid, bus.id_kill}, 32'd0);
    step();
    check("stall_c3_no_pulse", {29'd0, bus.ctrl_branch, bus.flush_ifid, bus.id_kill}, 32'd0);
    bus.opnd_ready = 1'b1;
    #1;
    check("stall_release", {31'd0, bus.stall_req}, 32'd0);
    step();
    exp_taken++;
    bus.opnd_ready = 1'b0;
    #1;
    check("stall_redirect", {31'd0, bus.ctrl_branch}, 32'd1);
    check("stall_target", bus.branch_to_where, 32'h0000_4004);
    check("redirect_ignores_opnd", {31'd0, bus.stall_req}, 32'd0);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    check("stall_pulse_once", {31'd0, bus.ctrl_branch}, 32'd0);

    // signed compares on rs = 0x80000000, imm 0xFFFF gives pc+4-4
    drive(1'b1, i_type(OP_BGTZ, 5'd5, 5'd0, 16'hFFFF), 32'h0000_5000, 32'h8000_0000, 32'd0, 1'b1);
    step();
    exp_nt++;
    drive(1'b1, i_type(OP_BLEZ, 5'd5, 5'd0, 16'hFFFF), 32'h0000_5000, 32'h8000_0000, 32'd0, 1'b1);
    check("bgtz_not_taken", {31'd0, bus.ctrl_branch}, 32'd0);
    step();
    exp_taken++;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    check("blez_taken", {31'd0, bus.ctrl_branch}, 32'd1);
    check("blez_target", bus.branch_to_where, 32'h0000_4FFC);
    check_counters("signed");
    step();

    // reset in the middle of a jump redirect
    drive(1'b1, j_type(OP_J, 26'h000_0100), 32'h0000_6000, 32'd0, 32'd0, 1'b1);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    check("j_ctrl_jump", {31'd0, bus.ctrl_jump}, 32'd1);
    check("j_target", bus.jump_to_where, 32'h0000_0400);
    #1 rst = 1'b1;
    #1;
    check("midrst_pulses", {27'd0, bus.ctrl_jump, bus.ctrl_branch, bus.flush_ifid, bus.id_kill, bus.link_we}, 32'd0);
    check("midrst_jump_to_where", bus.jump_to_where, 32'd0);
    check("midrst_branch_to_where", bus.branch_to_where, 32'd0);
    exp_taken = 0;
    exp_nt    = 0;
    check_counters("midrst");
    #1 rst = 1'b0;
    step();
    check("postrst_no_pulse", {30'd0, bus.ctrl_jump, bus.flush_ifid}, 32'd0);

    // jr after reset: target is rs_val
    drive(1'b1, r_type(5'd8, 5'd0, FN_JR), 32'h0000_7000, 32'h0000_3000, 32'd0, 1'b1);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    check("jr_ctrl_jump", {31'd0, bus.ctrl_jump}, 32'd1);
    check("jr_target", bus.jump_to_where, 32'h0000_3000);
    check("jr_link_we", {31'd0, bus.link_we}, 32'd0);
    step();

    // jalr links to rd, low target bits unmasked
    drive(1'b1, r_type(5'd9, 5'd5, FN_JALR), 32'h0000_7004, 32'h0000_1235, 32'd0, 1'b1);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    check("jalr_target", bus.jump_to_where, 32'h0000_1235);
    check("jalr_link", {26'd0, bus.link_we, bus.link_addr}, {26'd0, 1'b1, 5'd5});
    check("jalr_link_data", bus.link_data, 32'h0000_7004);
    check_counters("final");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
